// File: rtl/wb_queue.sv
// Write-back queue: merges ALU (port A) and load/MDU (port B) results into an
// in-order FIFO that drains one register-file write per cycle, and exposes
// two hazard lookups that return the youngest pending value for an address.
//
// Handshake: a transfer happens on a port when valid && ready at a rising
// edge. Ready is derived only from the registered occupancy (never from
// valid), so upstream can sample it freely. A is always older than B when
// both transfer on the same edge. Transfers to address 0 complete the
// handshake but are not stored.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     rf_write_en,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic [DATA_W-1:0]        rf_write_data,
    input  logic [ADDR_W-1:0]        lk_addr_1,
    input  logic [ADDR_W-1:0]        lk_addr_2,
    output logic                     lk_hit_1,
    output logic                     lk_hit_2,
    output logic [DATA_W-1:0]        lk_data_1,
    output logic [DATA_W-1:0]        lk_data_2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [CNT_W-1:0]  free;
    logic              push_a, push_b, pop;
    logic [PTR_W-1:0]  tail_b;
    logic [DATA_W:0]   lk_res_1, lk_res_2;

    // Youngest occupied entry matching key wins; result is {hit, data}.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] key);
        logic [DATA_W:0] res;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (key != '0) &&
                (addr_q[head_q + PTR_W'(i)] == key)) begin
                res = {1'b1, data_q[head_q + PTR_W'(i)]};
            end
        end
        return res;
    endfunction

    // Handshake, push/pop decisions and next-state pointers/occupancy.
    always_comb begin
        free    = CNT_W'(DEPTH) - count_q;
        a_ready = rst && (free >= CNT_W'(1));
        b_ready = rst && (free >= CNT_W'(2));
        push_a  = a_valid && a_ready && (a_addr != '0);
        push_b  = b_valid && b_ready && (b_addr != '0);
        pop     = (count_q != '0);
        tail_b  = tail_q + PTR_W'(push_a);
        tail_d  = tail_q + PTR_W'(push_a) + PTR_W'(push_b);
        head_d  = head_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end

    // Queue state: pointers, occupancy and entry storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_a) begin
                addr_q[tail_q] <= a_addr;
                data_q[tail_q] <= a_data;
            end
            if (push_b) begin
                addr_q[tail_b] <= b_addr;
                data_q[tail_b] <= b_data;
            end
        end
    end

    // Register-file write port shows the head entry; silent when empty or in reset.
    always_comb begin
        rf_write_en   = rst && pop;
        rf_write_addr = rf_write_en ? addr_q[head_q] : '0;
        rf_write_data = rf_write_en ? data_q[head_q] : '0;
        count         = count_q;
    end

    // Hazard lookups over stored entries only (in-flight transfers are invisible).
    always_comb begin
        lk_res_1  = rst ? lookup(lk_addr_1) : '0;
        lk_res_2  = rst ? lookup(lk_addr_2) : '0;
        lk_hit_1  = lk_res_1[DATA_W];
        lk_data_1 = lk_res_1[DATA_W-1:0];
        lk_hit_2  = lk_res_2[DATA_W];
        lk_data_2 = lk_res_2[DATA_W-1:0];
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: hand-written transfers with hand-computed
// readiness, occupancy and lookup results; a retire monitor compares every
// register-file write against the queue of entries expected to be pending.
module tb_wb_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] lk_addr_1, lk_addr_2;
    logic              lk_hit_1, lk_hit_2;
    logic [DATA_W-1:0] lk_data_1, lk_data_2;
    logic [CNT_W-1:0]  count;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .lk_addr_1(lk_addr_1), .lk_addr_2(lk_addr_2),
        .lk_hit_1(lk_hit_1), .lk_hit_2(lk_hit_2),
        .lk_data_1(lk_data_1), .lk_data_2(lk_data_2),
        .count(count)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer cycle; exp_ar/exp_br are the hand-computed ready values.
    task automatic cyc(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                       input logic exp_ar, input logic exp_br);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        check("a_ready", a_ready, exp_ar);
        check("b_ready", b_ready, exp_br);
        @(posedge clk);
        if (av && exp_ar && aa != '0) exp_q.push_back({aa, ad});
        if (bv && exp_br && ba != '0) exp_q.push_back({ba, bd});
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // retire monitor: one register-file write per cycle, in enqueue order
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] ent;
        if (rst) begin
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                check("rf_en", rf_write_en, 1);
                check("rf_addr", rf_write_addr, ent[DATA_W +: ADDR_W]);
                check("rf_data", rf_write_data, ent[DATA_W-1:0]);
            end else begin
                check("rf_en_idle", rf_write_en, 0);
                check("rf_addr_idle", rf_write_addr, 0);
                check("rf_data_idle", rf_write_data, 0);
            end
        end
    end

    initial begin
        rst = 1'b0;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        lk_addr_1 = 0; lk_addr_2 = 0;

        // reset: outputs quiet, no readiness even with valid high
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1; a_addr = 3; b_valid = 1; b_addr = 4; lk_addr_1 = 3;
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_rf_en", rf_write_en, 0);
        check("rst_lk_hit", lk_hit_1, 0);
        check("rst_lk_data", lk_data_1, 0);
        a_valid = 0; b_valid = 0;
        step();
        rst = 1'b1;
        check("rst_count", count, 0);

        // single push, in-flight entry not visible to lookup
        a_valid = 1; a_addr = 3; a_data = 32'h11;
        #1;
        check("lk_inflight", lk_hit_1, 0);
        cyc(1, 5'd3, 32'h11, 0, 5'd0, 32'h0, 1, 1);
        check("single_count1", count, 1);
        check("single_lk_hit", lk_hit_1, 1);
        check("single_lk_data", lk_data_1, 32'h11);
        step();
        check("single_count0", count, 0);

        // dual push into empty queue: 4/AA then 5/BB
        cyc(1, 5'd4, 32'hAA, 1, 5'd5, 32'hBB, 1, 1);
        check("dual_count2", count, 2);
        step();
        check("dual_count1", count, 1);
        step();
        check("dual_count0", count, 0);

        // zero address: accepted, not stored
        cyc(1, 5'd0, 32'hFF, 0, 5'd0, 32'h0, 1, 1);
        check("zero_count", count, 0);
        step();
        check("zero_count2", count, 0);

        // fill/backpressure: dual pushes every cycle, occupancy settles at 3
        for (int k = 0; k < 6; k++) begin
            cyc(1, 5'(k + 1), 32'h100 + 32'(k), 1, 5'(k + 10), 32'h200 + 32'(k), 1, (k < 2));
            check("fill_count", count, (k == 0) ? 2 : 3);
        end
        step();
        check("drain_count2", count, 2);
        step();
        check("drain_count1", count, 1);
        step();
        check("drain_count0", count, 0);

        // lookup youngest: queue holds (7,1),(9,2),(7,3)
        lk_addr_1 = 7; lk_addr_2 = 0;
        cyc(1, 5'd2, 32'h55, 1, 5'd7, 32'h1, 1, 1);
        check("lk_count2", count, 2);
        cyc(1, 5'd9, 32'h2, 1, 5'd7, 32'h3, 1, 1);
        check("lk_count3", count, 3);
        check("lk1_hit", lk_hit_1, 1);
        check("lk1_data", lk_data_1, 32'h3);
        check("lk2_zero_hit", lk_hit_2, 0);
        check("lk2_zero_data", lk_data_2, 0);
        lk_addr_2 = 8;
        #1;
        check("lk2_miss_hit", lk_hit_2, 0);
        check("lk2_miss_data", lk_data_2, 0);
        lk_addr_2 = 9;
        #1;
        check("lk2_9_hit", lk_hit_2, 1);
        check("lk2_9_data", lk_data_2, 32'h2);
        repeat (3) step();
        check("lk_drain_count", count, 0);
        check("lk_empty_hit", lk_hit_1, 0);

        // reset mid-operation with 3 entries pending
        lk_addr_1 = 11;
        cyc(1, 5'd6, 32'h61, 1, 5'd8, 32'h62, 1, 1);
        cyc(1, 5'd10, 32'h63, 1, 5'd11, 32'h64, 1, 1);
        check("mid_count3", count, 3);
        rst = 1'b0;
        #1;
        check("mid_rst_rf_en", rf_write_en, 0);
        check("mid_rst_a_ready", a_ready, 0);
        check("mid_rst_lk_hit", lk_hit_1, 0);
        @(posedge clk);
        exp_q.delete();
        #1;
        rst = 1'b1;
        #1;
        check("mid_count0", count, 0);
        check("mid_rf_en", rf_write_en, 0);
        check("mid_lk_hit", lk_hit_1, 0);
        repeat (3) step();
        check("mid_idle_count", count, 0);
        cyc(1, 5'd12, 32'h70, 0, 5'd0, 32'h0, 1, 1);
        check("post_rst_count1", count, 1);
        repeat (2) step();
        check("post_rst_count0", count, 0);

        check("drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEPTH, 4, queue entries (power of two, >=2).
REQ-002 Parameters SHALL be (name, default, meaning): ADDR_W, 5, register address width.
REQ-003 Parameters SHALL be (name, default, meaning): DATA_W, 32, register data width.
REQ-004 Reset is rst, synchronous, active-low; clock is clk.
REQ-005 Ports SHALL be (name, direction, width, meaning) as follows:
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-low reset
 a_valid  in  1  port A (ALU result) write request
 a_ready  out  1  port A can accept
 a_addr  in  ADDR_W  port A destination register
 a_data  in  DATA_W  port A result
 b_valid  in  1  port B (load/MDU result) write request
 b_ready  out  1  port B can accept
 b_addr  in  ADDR_W  port B destination register
 b_data  in  DATA_W  port B result
 rf_write_en  out  1  register-file write enable
 rf_write_addr  out  ADDR_W  register-file write address
 rf_write_data  out  DATA_W  register-file write data
 lk_addr_1, lk_addr_2  in  ADDR_W  hazard lookup addresses
 lk_hit_1, lk_hit_2  out  1  pending write to lookup address exists
 lk_data_1, lk_data_2  out  DATA_W  youngest pending data for lookup address
 count  out  clog2(DEPTH)+1  occupied entries

Function
REQ-006 Queue SHALL be an in-order FIFO of {addr, data} entries with head/tail pointers wrapping modulo DEPTH.
REQ-007 A transfer SHALL occur on a port when valid and ready are both high at a rising edge.
REQ-008 free = DEPTH - count (registered count; current-cycle pop not credited); a_ready = (free >= 1); b_ready = (free >= 2).
REQ-009 a_ready and b_ready SHALL NOT depend on a_valid or b_valid.
REQ-010 Same-edge transfers on both ports: A entry SHALL be enqueued before B entry (A older).
REQ-011 A transfer whose addr is 0 SHALL be accepted (handshake completes) but SHALL NOT create an entry.
REQ-012 rf_write_en = (count != 0); rf_write_addr/rf_write_data = head entry, combinational from state; all zero when empty.
REQ-013 Head SHALL be popped at every rising edge where count != 0 (register file always accepts).
REQ-014 Latency: entry enqueued into an empty queue at edge N SHALL appear on the rf_write port during the cycle after edge N and retire at edge N+1.
REQ-015 count(next) = count + pushes(0..2) - pop(0/1); simultaneous push and pop at any occupancy SHALL be exact, never exceeding DEPTH nor underflowing.
REQ-016 lk_hit_x = 1 iff lk_addr_x != 0 and any occupied entry (head included) has addr == lk_addr_x; combinational.
REQ-017 lk_data_x SHALL be data of the youngest (closest to tail) matching entry; 0 when lk_hit_x = 0.
REQ-018 Entries in flight on a/b ports that same cycle SHALL NOT be visible to lookup until after enqueue.
REQ-019 No entry SHALL be dropped or reordered; duplicate addresses SHALL retire in enqueue order.

Reset
REQ-020 While rst = 0 at a rising edge: head = tail = 0, count = 0, entries cleared to 0.
REQ-021 During and after reset: rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0, lk_hit_x = 0, lk_data_x = 0, a_ready = 0, b_ready = 0 while rst = 0.
REQ-022 Reset mid-operation SHALL discard all pending entries; no write SHALL be issued in the cycle after reset deasserts unless a new transfer occurred.

Verification
REQ-023 Single push: a_valid, a_addr=3, a_data=0x11 at edge 1 -> next cycle rf_write_en=1, addr=3, data=0x11; count=0 after edge 2.
REQ-024 Dual push: A(4,0xAA) and B(5,0xBB) same edge into empty queue -> rf writes 4/0xAA then 5/0xBB on consecutive cycles; count 2,1,0.
REQ-025 Zero address: a_addr=0, a_data=0xFF -> a handshake completes, count stays 0, rf_write_en stays 0.
REQ-026 Fill/backpressure: dual pushes every cycle from empty -> count saturates at DEPTH-1 or DEPTH, b_ready=0 when free<2, a_ready=0 when full; all accepted entries retire in order, none lost.
REQ-027 Lookup youngest: queue holds (7,0x1),(9,0x2),(7,0x3) -> lk_addr_1=7 gives hit=1, data=0x3; lk_addr_2=0 gives hit=0, data=0; lk_addr_2=8 gives hit=0.
REQ-028 Reset mid-operation: 3 entries pending, rst=0 for one edge -> count=0, rf_write_en=0, lk_hit=0 next cycle; pending writes never appear.
